regfile_arbiter: RTL and testbench
==================================

REGFILE_ARBITER -- requirements
Module: regfile_arbiter

Interface
REQ-001 The block SHALL have parameter DW, default 16, meaning the data word width.
REQ-002 The block SHALL have parameter AW, default 4, meaning the register address width (16 registers).
REQ-003 The block SHALL have parameter ACC_BASE, default 12, meaning the address of the first accumulator (ACC0).
REQ-004 The block SHALL have parameter ACC_CNT, default 4, meaning the number of accumulators cleared by a clear sequence.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: a synchronous, active-low reset.
REQ-007 For each n in {0,1}, the block SHALL have port reqn_valid, input, 1 bit: request n is pending.
REQ-008 For each n in {0,1}, the block SHALL have port reqn_ready, output, 1 bit: request n is accepted this cycle.
REQ-009 For each n in {0,1}, the block SHALL have ports reqn_we (input, 1 bit: write), reqn_x and reqn_y (inputs, AW bits: read addresses), reqn_z (input, AW bits: write address) and reqn_wdata (input, DW bits: write data).
REQ-010 For each n in {0,1}, the block SHALL have port rspn_valid, output, 1 bit: a one-cycle response pulse for request n.
REQ-011 The block SHALL have ports rsp_rx and rsp_ry, outputs, DW bits: the captured read data, shared by both requesters.
REQ-012 The block SHALL have port clr_start (input, 1 bit: begin an accumulator clear), port clr_busy (output, 1 bit) and port clr_done (output, 1 bit: pulse).
REQ-013 The block SHALL have ports rf_WR and rf_RD (outputs, 1 bit), rf_x, rf_y and rf_z (outputs, AW bits) and rf_Rz (output, DW bits), which drive the register file.
REQ-014 The block SHALL have ports rf_Rx and rf_Ry, inputs, DW bits: the combinational read data from the register file.

Function
REQ-015 The FSM SHALL have the states IDLE, ISSUE, RESP and CLEAR.
REQ-016 reqn_ready SHALL be asserted only in IDLE or RESP, and only when clr_start is low; at most one ready SHALL be high per cycle.
REQ-017 When a single request is valid, that request SHALL be granted; when both are valid, the request other than last_grant SHALL be granted, and last_grant SHALL update on every accept.
REQ-018 An accepted request SHALL be registered at the accept edge, and the FSM SHALL then enter ISSUE.
REQ-019 In ISSUE, the block SHALL drive rf_RD=1, rf_x/rf_y from the latched request, and rf_WR equal to the latched we, with rf_z/rf_Rz from the latched request.
REQ-020 The block SHALL capture rf_Rx/rf_Ry into rsp_rx/rsp_ry at the end of ISSUE, then enter RESP.
REQ-021 In RESP, the block SHALL pulse rspn_valid for exactly one cycle, for writes and reads alike; the response has no backpressure.
REQ-022 Latency SHALL be 2 cycles from accept to rsp_valid; back-to-back accepts in RESP SHALL give one operation per 2 cycles.
REQ-023 When a read address equals the write address in the same ISSUE cycle, the response SHALL return the pre-write value.
REQ-024 clr_start sampled high in IDLE or RESP SHALL take priority over requests and enter CLEAR; clr_start in ISSUE or CLEAR SHALL be ignored.
REQ-025 CLEAR SHALL last ACC_CNT cycles and drive rf_WR=1, rf_Rz=0 and rf_z=ACC_BASE+cnt, with a counter running 0..ACC_CNT-1; rf_RD SHALL be 0.
REQ-026 clr_busy SHALL be high throughout CLEAR, and clr_done SHALL pulse in the final CLEAR cycle; the FSM SHALL then go to IDLE.
REQ-027 Outside ISSUE and CLEAR, rf_WR and rf_RD SHALL be 0, and all rf address and data outputs SHALL be 0.
REQ-028 The block SHALL not modify requester addresses; address arithmetic is AW bits wide.

Reset
REQ-029 While reset is low at a clock edge, the block SHALL set state=IDLE, last_grant=1 (so req0 wins first), cnt=0 and rsp_rx=rsp_ry=0.
REQ-030 rf_WR SHALL be combinationally forced to 0 while reset is low, so that no register file write occurs at a reset edge even mid-ISSUE or mid-CLEAR.
REQ-031 An in-flight operation aborted by reset SHALL be dropped, with no rsp_valid.
REQ-032 All ready, rsp_valid, clr_busy and clr_done outputs SHALL be 0 during reset.

Structure
REQ-033 A shared package SHALL hold the state enum, DW, AW, ACC_BASE and ACC_CNT.
REQ-034 A sub-module rr_arbiter2 SHALL implement the two-way round-robin with last_grant; all other logic SHALL remain in regfile_arbiter.

Verification
REQ-035 Reset, then req0 write z=3, wdata=0xBEEF; then req1 read x=3, y=0 -> rsp1_valid 2 cycles after accept, rsp_rx=0xBEEF, rsp_ry=0.
REQ-036 Both requesters valid continuously -> grants alternate 0,1,0,1, with a response every 2 cycles.
REQ-037 Write z=5, wdata=0x1234 while reading x=5, where R5 was 0x0001 -> rsp_rx=0x0001; a subsequent read returns 0x1234.
REQ-038 Load ACC0..ACC3 with 0xFFFF, pulse clr_start -> clr_busy for 4 cycles, clr_done on the 4th, reads of regs 12..15 return 0, and R11 is unchanged.
REQ-039 clr_start and req0_valid raised in the same IDLE cycle -> CLEAR first, with req0 accepted after clr_done.
REQ-040 Assert reset during ISSUE of a write to z=7 -> R7 unchanged, no rsp_valid, FSM in IDLE.

Source files
------------

// File: rtl/regfile_arbiter_pkg.sv
// Shared definitions for the register-file arbiter: default widths,
// accumulator window and the controller state encoding.
package regfile_arbiter_pkg;

    localparam int DW       = 16;
    localparam int AW       = 4;
    localparam int ACC_BASE = 12;
    localparam int ACC_CNT  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2,
        CLEAR = 2'd3
    } state_t;

endpackage

// File: rtl/regfile_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter. A contested cycle goes to the requester that
// did not win the previous accept; reset leaves last_grant at 1 so req0
// wins the first contested cycle.
module rr_arbiter2 (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1
);

    logic last_grant;

    // Grant decode: only while accepts are allowed, alternate on contention.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (en) begin
            if (req0 && req1) begin
                gnt0 = last_grant;
                gnt1 = !last_grant;
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
    end

    // Remember the winner of every accept.
    always_ff @(posedge clk) begin
        if (!reset) begin
            last_grant <= 1'b1;
        end else if (gnt0 || gnt1) begin
            last_grant <= gnt1;
        end
    end

endmodule

// File: rtl/regfile_arbiter.sv
// Arbitrates two requesters onto a single-port-style register file interface
// and runs a fixed-length accumulator clear sequence. Each accepted request
// spends one cycle in ISSUE (read + optional write) and one in RESP, where
// the captured read data is presented with a one-cycle valid pulse.
module regfile_arbiter
    import regfile_arbiter_pkg::*;
#(
    parameter int DW       = regfile_arbiter_pkg::DW,
    parameter int AW       = regfile_arbiter_pkg::AW,
    parameter int ACC_BASE = regfile_arbiter_pkg::ACC_BASE,
    parameter int ACC_CNT  = regfile_arbiter_pkg::ACC_CNT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic          req0_we,
    input  logic [AW-1:0] req0_x,
    input  logic [AW-1:0] req0_y,
    input  logic [AW-1:0] req0_z,
    input  logic [DW-1:0] req0_wdata,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic          req1_we,
    input  logic [AW-1:0] req1_x,
    input  logic [AW-1:0] req1_y,
    input  logic [AW-1:0] req1_z,
    input  logic [DW-1:0] req1_wdata,
    output logic          rsp0_valid,
    output logic          rsp1_valid,
    output logic [DW-1:0] rsp_rx,
    output logic [DW-1:0] rsp_ry,
    input  logic          clr_start,
    output logic          clr_busy,
    output logic          clr_done,
    output logic          rf_WR,
    output logic          rf_RD,
    output logic [AW-1:0] rf_x,
    output logic [AW-1:0] rf_y,
    output logic [AW-1:0] rf_z,
    output logic [DW-1:0] rf_Rz,
    input  logic [DW-1:0] rf_Rx,
    input  logic [DW-1:0] rf_Ry
);

    localparam logic [AW-1:0] ACC_Z0   = AW'(ACC_BASE);
    localparam logic [AW-1:0] CNT_LAST = AW'(ACC_CNT - 1);

    state_t        state;
    logic [AW-1:0] cnt;
    logic          lat_id;
    logic          lat_we;
    logic [AW-1:0] lat_x;
    logic [AW-1:0] lat_y;
    logic [AW-1:0] lat_z;
    logic [DW-1:0] lat_wdata;
    logic [DW-1:0] rx_reg;
    logic [DW-1:0] ry_reg;
    logic          accept_window;
    logic          accept;
    logic          wr_raw;

    // A clear request in an accepting state wins over both requesters.
    assign accept_window = reset && !clr_start && (state == IDLE || state == RESP);
    assign accept        = req0_ready || req1_ready;

    rr_arbiter2 u_arb (
        .clk   (clk),
        .reset (reset),
        .en    (accept_window),
        .req0  (req0_valid),
        .req1  (req1_valid),
        .gnt0  (req0_ready),
        .gnt1  (req1_ready)
    );

    // Controller: latch accepted requests, capture read data, sequence clears.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            rx_reg    <= '0;
            ry_reg    <= '0;
            lat_id    <= 1'b0;
            lat_we    <= 1'b0;
            lat_x     <= '0;
            lat_y     <= '0;
            lat_z     <= '0;
            lat_wdata <= '0;
        end else begin
            case (state)
                IDLE, RESP: begin
                    if (clr_start) begin
                        state <= CLEAR;
                        cnt   <= '0;
                    end else if (accept) begin
                        lat_id    <= req1_ready;
                        lat_we    <= req1_ready ? req1_we    : req0_we;
                        lat_x     <= req1_ready ? req1_x     : req0_x;
                        lat_y     <= req1_ready ? req1_y     : req0_y;
                        lat_z     <= req1_ready ? req1_z     : req0_z;
                        lat_wdata <= req1_ready ? req1_wdata : req0_wdata;
                        state     <= ISSUE;
                    end else begin
                        state <= IDLE;
                    end
                end
                ISSUE: begin
                    // Read data is sampled at the same edge as the write,
                    // so a read of the written address returns the old value.
                    rx_reg <= rf_Rx;
                    ry_reg <= rf_Ry;
                    state  <= RESP;
                end
                CLEAR: begin
                    if (cnt == CNT_LAST) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Register-file drive: active only in ISSUE and CLEAR, zero otherwise.
    always_comb begin
        wr_raw = 1'b0;
        rf_RD  = 1'b0;
        rf_x   = '0;
        rf_y   = '0;
        rf_z   = '0;
        rf_Rz  = '0;
        case (state)
            ISSUE: begin
                rf_RD  = 1'b1;
                wr_raw = lat_we;
                rf_x   = lat_x;
                rf_y   = lat_y;
                rf_z   = lat_z;
                rf_Rz  = lat_wdata;
            end
            CLEAR: begin
                wr_raw = 1'b1;
                rf_z   = ACC_Z0 + cnt;
            end
            default: ;
        endcase
    end

    // Reset masks the write strobe so no write lands on a reset edge.
    assign rf_WR = wr_raw && reset;

    assign rsp0_valid = reset && (state == RESP) && !lat_id;
    assign rsp1_valid = reset && (state == RESP) && lat_id;
    assign rsp_rx     = rx_reg;
    assign rsp_ry     = ry_reg;
    assign clr_busy   = reset && (state == CLEAR);
    assign clr_done   = clr_busy && (cnt == CNT_LAST);

endmodule

// File: tb/tb_regfile_arbiter.sv
// Bench for regfile_arbiter: a behavioural register file is attached to the
// rf_* port, a transaction-level model predicts grants, read data and
// timing, and a monitor compares each response against a scoreboard queue.
module tb_regfile_arbiter;

    localparam int ACC_BASE = 12;
    localparam int ACC_CNT  = 4;

    typedef struct {
        logic       we;
        logic [3:0] x, y, z;
        logic [15:0] wd;
    } req_t;

    typedef struct {
        bit          id;
        logic [15:0] rx, ry;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic        req0_we = 1'b0, req1_we = 1'b0;
    logic [3:0]  req0_x = '0, req0_y = '0, req0_z = '0;
    logic [3:0]  req1_x = '0, req1_y = '0, req1_z = '0;
    logic [15:0] req0_wdata = '0, req1_wdata = '0;
    logic        rsp0_valid, rsp1_valid;
    logic [15:0] rsp_rx, rsp_ry;
    logic        clr_start = 1'b0;
    logic        clr_busy, clr_done;
    logic        rf_WR, rf_RD;
    logic [3:0]  rf_x, rf_y, rf_z;
    logic [15:0] rf_Rz, rf_Rx, rf_Ry;

    regfile_arbiter dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
        .req0_x(req0_x), .req0_y(req0_y), .req0_z(req0_z), .req0_wdata(req0_wdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
        .req1_x(req1_x), .req1_y(req1_y), .req1_z(req1_z), .req1_wdata(req1_wdata),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
        .rsp_rx(rsp_rx), .rsp_ry(rsp_ry),
        .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
        .rf_WR(rf_WR), .rf_RD(rf_RD), .rf_x(rf_x), .rf_y(rf_y), .rf_z(rf_z),
        .rf_Rz(rf_Rz), .rf_Rx(rf_Rx), .rf_Ry(rf_Ry)
    );

    always #5 clk = ~clk;

    // Behavioural register file: combinational read, write on the edge.
    logic [15:0] rf_mem [16];
    bit          preload = 1'b1;
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 16; i++) rf_mem[i] <= 16'h1000 + 16'(i * 16'h0111);
        end else if (rf_WR) begin
            rf_mem[rf_z] <= rf_Rz;
        end
    end
    assign rf_Rx = rf_mem[rf_x];
    assign rf_Ry = rf_mem[rf_y];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference state
    logic [15:0] ref_regs [16];
    bit          mlast = 1'b1;
    int          free_at = 0;
    int          clr_lo = 0, clr_hi = -1;
    exp_t        q[$];
    int          n_cmp = 0, n_bad = 0;

    // Pending requester transactions
    bit   v0 = 1'b0, v1 = 1'b0;
    req_t p0, p1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One cycle of stimulus plus the model's prediction of what gets accepted.
    task automatic do_cycle(input bit clr);
        bit   e0, e1, win;
        req_t p;
        exp_t e;
        @(negedge clk);
        req0_valid = v0; req0_we = p0.we; req0_x = p0.x; req0_y = p0.y;
        req0_z = p0.z; req0_wdata = p0.wd;
        req1_valid = v1; req1_we = p1.we; req1_x = p1.x; req1_y = p1.y;
        req1_z = p1.z; req1_wdata = p1.wd;
        clr_start = clr;
        #1;
        e0 = 1'b0; e1 = 1'b0;
        if (cyc >= free_at) begin
            if (clr) begin
                clr_lo  = cyc + 1;
                clr_hi  = cyc + ACC_CNT;
                free_at = cyc + ACC_CNT + 1;
                for (int k = 0; k < ACC_CNT; k++) ref_regs[ACC_BASE + k] = 16'h0000;
            end else if (v0 || v1) begin
                win = (v0 && v1) ? !mlast : v1;
                p   = win ? p1 : p0;
                e.id = win; e.rx = ref_regs[p.x]; e.ry = ref_regs[p.y]; e.cyc = cyc + 2;
                q.push_back(e);
                if (p.we) ref_regs[p.z] = p.wd;
                mlast   = win;
                free_at = cyc + 2;
                e0 = !win; e1 = win;
            end
        end
        check("req0_ready", req0_ready, e0);
        check("req1_ready", req1_ready, e1);
        if (e0) v0 = 1'b0;
        if (e1) v1 = 1'b0;
    endtask

    task automatic drain_requests(input string name);
        int n;
        n = 0;
        while ((v0 || v1) && n < 20) begin
            do_cycle(1'b0);
            n++;
        end
        n_cmp++;
        if (v0 || v1) begin
            n_bad++;
            $display("FAIL %s: request not accepted within 20 cycles", name);
            v0 = 1'b0; v1 = 1'b0;
        end
    endtask

    function automatic req_t mk(input logic we, input logic [3:0] x, input logic [3:0] y,
                                input logic [3:0] z, input logic [15:0] wd);
        req_t r;
        r.we = we; r.x = x; r.y = y; r.z = z; r.wd = wd;
        return r;
    endfunction

    function automatic req_t rnd_req();
        return mk(1'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 16'($urandom));
    endfunction

    // Monitor: compares every response and the clear handshake each cycle.
    initial begin
        exp_t e;
        bit   exp_busy;
        forever begin
            @(negedge clk);
            #2;
            exp_busy = (cyc >= clr_lo) && (cyc <= clr_hi);
            check("clr_busy", clr_busy, exp_busy);
            check("clr_done", clr_done, exp_busy && (cyc == clr_hi));
            if (rsp0_valid && rsp1_valid) check("rsp_onehot", 2'b11, 2'b01);
            if (rsp0_valid || rsp1_valid) begin
                if (q.size() == 0) begin
                    check("rsp_unexpected", {rsp1_valid, rsp0_valid}, 2'b00);
                end else begin
                    e = q.pop_front();
                    check("rsp_id",    rsp1_valid, e.id);
                    check("rsp_cycle", cyc, e.cyc);
                    check("rsp_rx",    rsp_rx, e.rx);
                    check("rsp_ry",    rsp_ry, e.ry);
                end
            end else if (q.size() != 0 && q[0].cyc <= cyc) begin
                e = q.pop_front();
                check("rsp_missing", 1'b0, 1'b1);
            end
        end
    end

    initial begin
        logic [15:0] saved;
        p0 = mk(0, 0, 0, 0, 0);
        p1 = mk(0, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) ref_regs[i] = 16'h1000 + 16'(i * 16'h0111);

        // Reset: outputs quiet even with a request and a clear pending.
        req0_valid = 1'b1; clr_start = 1'b1;
        repeat (3) begin
            @(negedge clk); #1;
            check("rst_ready0", req0_ready, 1'b0);
            check("rst_rf_WR", rf_WR, 1'b0);
            check("rst_rsp_rx", rsp_rx, 16'h0);
            check("rst_rsp_ry", rsp_ry, 16'h0);
            check("rst_clr_busy", clr_busy, 1'b0);
        end
        preload = 1'b0;
        req0_valid = 1'b0; clr_start = 1'b0;
        reset = 1'b1;
        free_at = cyc;

        // Write R3, then read it back from the other requester.
        p0 = mk(1, 0, 0, 3, 16'hBEEF); v0 = 1'b1;
        drain_requests("wr_r3");
        p1 = mk(0, 3, 0, 0, 16'h0); v1 = 1'b1;
        drain_requests("rd_r3");

        // Both requesters always valid: grants must alternate.
        for (int i = 0; i < 12; i++) begin
            if (!v0) begin p0 = rnd_req(); v0 = 1'b1; end
            if (!v1) begin p1 = rnd_req(); v1 = 1'b1; end
            do_cycle(1'b0);
        end
        drain_requests("contend");

        // Read-during-write of the same register returns the old value.
        p0 = mk(1, 0, 0, 5, 16'h0001); v0 = 1'b1;
        drain_requests("set_r5");
        p0 = mk(1, 5, 5, 5, 16'h1234); v0 = 1'b1;
        drain_requests("rdw_r5");
        p1 = mk(0, 5, 11, 0, 16'h0); v1 = 1'b1;
        drain_requests("rd_r5");

        // Fill accumulators, clear them, read them and R11 back.
        for (int k = 0; k < ACC_CNT; k++) begin
            p0 = mk(1, 0, 0, 4'(ACC_BASE + k), 16'hFFFF); v0 = 1'b1;
            drain_requests("acc_fill");
        end
        repeat (2) do_cycle(1'b0);
        do_cycle(1'b1);
        repeat (ACC_CNT + 1) do_cycle(1'b0);
        p0 = mk(0, 12, 13, 0, 16'h0); v0 = 1'b1;
        p1 = mk(0, 14, 15, 0, 16'h0); v1 = 1'b1;
        drain_requests("acc_read");
        p0 = mk(0, 11, 11, 0, 16'h0); v0 = 1'b1;
        drain_requests("r11_read");

        // Clear and request in the same idle cycle: clear goes first.
        repeat (2) do_cycle(1'b0);
        p0 = mk(0, 3, 5, 0, 16'h0); v0 = 1'b1;
        do_cycle(1'b1);
        drain_requests("clr_vs_req");

        // Reset during the ISSUE cycle of a write to R7.
        repeat (2) do_cycle(1'b0);
        saved = ref_regs[7];
        p0 = mk(1, 0, 0, 7, 16'hDEAD); v0 = 1'b1;
        drain_requests("wr_r7");
        @(negedge clk);
        reset = 1'b0;
        req0_valid = 1'b0;
        q.delete();
        ref_regs[7] = saved;
        #1;
        check("abort_rf_WR", rf_WR, 1'b0);
        @(negedge clk); #1;
        check("abort_rsp0", rsp0_valid, 1'b0);
        check("abort_r7", rf_mem[7], saved);
        reset = 1'b1;
        mlast = 1'b1;
        free_at = cyc;
        p1 = mk(0, 7, 0, 0, 16'h0); v1 = 1'b1;
        do_cycle(1'b0);
        drain_requests("rd_r7");

        // Randomised traffic with occasional clears.
        for (int i = 0; i < 400; i++) begin
            if (!v0 && ($urandom % 3 == 0)) begin p0 = rnd_req(); v0 = 1'b1; end
            if (!v1 && ($urandom % 3 == 0)) begin p1 = rnd_req(); v1 = 1'b1; end
            do_cycle($urandom % 25 == 0);
        end
        drain_requests("random_tail");
        repeat (ACC_CNT + 4) do_cycle(1'b0);

        check("queue_empty", q.size(), 0);
        for (int i = 0; i < 16; i++) check("final_rf", rf_mem[i], ref_regs[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
